// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: routes one stream bit per accepted cycle round-robin
// into four 4-bit channels and publishes the assembled 16-bit frame.
module tdm_demux (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        frame_start,
  output logic [15:0] frame_out,
  output logic        frame_valid,
  output logic [1:0]  sel_o,
  output logic        busy,
  output logic        sync_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] frame_q, frame_d;
  logic        fv_q, fv_d;
  logic        se_q, se_d;
  logic        accept;
  logic [3:0]  wr_pos;

  // A bit is taken either as the first bit of a new frame or as the next bit of a running one.
  assign accept = in_valid && (frame_start || (state_q == RUN));
  // Stream index i = 4k + c lands at position 4c + k, i.e. the two count halves swapped.
  assign wr_pos = frame_start ? 4'd0 : {count_q[1:0], count_q[3:2]};

  for (genvar gi = 0; gi < 16; gi++) begin : g_buf
    assign buf_d[gi] = (accept && (wr_pos == 4'(gi))) ? in_bit : buf_q[gi];
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    frame_d = frame_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (in_valid && frame_start) begin
      se_d    = (state_q == RUN);
      state_d = RUN;
      count_d = 4'd1;
    end else if (in_valid && (state_q == RUN)) begin
      if (count_q == 4'd15) begin
        // Final bit is merged straight into the published frame so it appears one clock later.
        frame_d = buf_d;
        fv_d    = 1'b1;
        state_d = IDLE;
        count_d = 4'd0;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      buf_q   <= 16'h0000;
      frame_q <= 16'h0000;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign busy        = (state_q == RUN);
  assign sel_o       = (state_q == RUN) ? count_q[1:0] : 2'd0;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: frames, gaps, stray bits, resync, reset abort, back-to-back.
module tb_tdm_demux;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        frame_start;
  logic [15:0] frame_out;
  logic        frame_valid;
  logic [1:0]  sel_o;
  logic        busy;
  logic        sync_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  int fv_cyc_prev = 0;
  int fv_cyc_last = 0;
  int fv_base, se_base;

  tdm_demux dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .frame_start(frame_start), .frame_out(frame_out), .frame_valid(frame_valid),
    .sel_o(sel_o), .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: samples pre-edge output values at each rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_valid) begin
      fv_cnt      <= fv_cnt + 1;
      fv_cyc_prev <= fv_cyc_last;
      fv_cyc_last <= cyc;
    end
    if (sync_err) se_cnt <= se_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic b, input logic fs);
    in_valid = 1'b1; in_bit = b; frame_start = fs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_bit = 1'b0; frame_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Stream bit i is pat[15-i]; optional 3-cycle gaps after bits 5 and 11.
  task automatic send_frame(input logic [15:0] pat, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      send(pat[15-i], i == 0);
      if (gaps && (i == 5 || i == 11)) begin
        for (int g = 0; g < 3; g++) begin
          idle(1);
          check("gap_sel", {30'd0, sel_o}, (i + 1) % 4);
          check("gap_busy", {31'd0, busy}, 1);
        end
      end
    end
  endtask

  localparam logic [15:0] PAT = 16'b1010_1001_0110_0101;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; frame_start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_frame_out", {16'd0, frame_out}, 16'h0000);
    check("rst_frame_valid", {31'd0, frame_valid}, 0);
    check("rst_sync_err", {31'd0, sync_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_sel", {30'd0, sel_o}, 0);
    rst = 1'b0;
    idle(1);

    // Basic frame.
    for (int i = 0; i < 16; i++) begin
      send(PAT[15-i], i == 0);
      if (i == 0)  check("a_busy_first", {31'd0, busy}, 1);
      if (i == 0)  check("a_sel_first", {30'd0, sel_o}, 1);
      if (i == 14) check("a_sel_14", {30'd0, sel_o}, 3);
      if (i == 14) check("a_fv_early", {31'd0, frame_valid}, 0);
    end
    check("a_frame_valid", {31'd0, frame_valid}, 1);
    check("a_frame_out", {16'd0, frame_out}, 16'hA5C3);
    check("a_busy_after", {31'd0, busy}, 0);
    idle(1);
    check("a_fv_drop", {31'd0, frame_valid}, 0);
    check("a_hold", {16'd0, frame_out}, 16'hA5C3);
    check("a_fv_cnt", fv_cnt, 1);

    // Stray valid bits while idle.
    fv_base = fv_cnt; se_base = se_cnt;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b0);
      check("c_busy", {31'd0, busy}, 0);
    end
    idle(2);
    check("c_frame_out", {16'd0, frame_out}, 16'hA5C3);
    check("c_fv_none", fv_cnt - fv_base, 0);
    check("c_se_none", se_cnt - se_base, 0);

    // Resync after 9 bits into an all-ones frame.
    fv_base = fv_cnt; se_base = se_cnt;
    for (int i = 0; i < 9; i++) send(PAT[15-i], i == 0);
    send(1'b1, 1'b1);
    check("d_sync_err", {31'd0, sync_err}, 1);
    check("d_sel_restart", {30'd0, sel_o}, 1);
    for (int i = 1; i < 16; i++) begin
      send(1'b1, 1'b0);
      if (i == 1) check("d_se_drop", {31'd0, sync_err}, 0);
    end
    check("d_frame_out", {16'd0, frame_out}, 16'hFFFF);
    idle(2);
    check("d_se_cnt", se_cnt - se_base, 1);
    check("d_fv_cnt", fv_cnt - fv_base, 1);

    // Frame with gaps.
    fv_base = fv_cnt;
    send_frame(PAT, 1'b1);
    check("b_frame_valid", {31'd0, frame_valid}, 1);
    check("b_frame_out", {16'd0, frame_out}, 16'hA5C3);
    idle(2);
    check("b_fv_cnt", fv_cnt - fv_base, 1);

    // Back-to-back frames.
    fv_base = fv_cnt; se_base = se_cnt;
    send_frame(16'hFFFF, 1'b0);
    send_frame(PAT, 1'b0);
    check("e_frame_out", {16'd0, frame_out}, 16'hA5C3);
    idle(2);
    check("e_fv_cnt", fv_cnt - fv_base, 2);
    check("e_spacing", fv_cyc_last - fv_cyc_prev, 16);
    check("e_se_none", se_cnt - se_base, 0);

    // Reset after 15 bits.
    fv_base = fv_cnt; se_base = se_cnt;
    for (int i = 0; i < 15; i++) send(PAT[15-i], i == 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(PAT[0], 1'b0);
    check("f_busy", {31'd0, busy}, 0);
    check("f_frame_out", {16'd0, frame_out}, 16'h0000);
    idle(2);
    check("f_fv_none", fv_cnt - fv_base, 0);
    check("f_se_none", se_cnt - se_base, 0);
    check("f_sel", {30'd0, sel_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
